// File: rtl/hh_sched_pkg.sv
// -----------------------------------------------------------------------------
// hh_sched_pkg
// Shared definitions for the Hodgkin-Huxley update scheduler:
//   - state_e      : scheduler FSM state encoding
//   - DEF_*        : default parameter values for the scheduler and its FIFO
//   - wait_cnt_w() : width of the saturating datapath wait counter
// -----------------------------------------------------------------------------
package hh_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_NUM_NEURONS = 4;
  localparam int DEF_ID_W        = 2;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_TIMEOUT     = 15;

  // The wait counter must be able to hold the value TIMEOUT itself.
  function automatic int wait_cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/spike_event_fifo.sv
// -----------------------------------------------------------------------------
// spike_event_fifo
// Small synchronous FIFO of neuron IDs that spiked during a sweep.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   push, push_id    : enqueue request and the ID to store
//   pop              : dequeue request (ignored while empty)
//   head_id          : ID at the head (0 while empty)
//   full, empty      : occupancy status
//   drop             : pulse; a push was discarded because the FIFO was full
// A push and a pop in the same cycle while full both succeed.
// -----------------------------------------------------------------------------
module spike_event_fifo
  import hh_sched_pkg::*;
#(
  parameter int ID_W       = DEF_ID_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push,
  input  logic [ID_W-1:0] push_id,
  input  logic            pop,
  output logic [ID_W-1:0] head_id,
  output logic            full,
  output logic            empty,
  output logic            drop
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ID_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  // NOTE: the storage array has no reset; the head is masked to zero while
  // empty, so stale contents are never visible and the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

  assign head_id = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hh_update_scheduler.sv
// -----------------------------------------------------------------------------
// hh_update_scheduler
// Time-multiplexes one shared Hodgkin-Huxley update datapath across
// NUM_NEURONS virtual neurons. Each accepted tick starts a sweep that issues
// one update per neuron in ascending ID order; spiking IDs are queued in a
// small event FIFO for the STDP/synapse logic. Error conditions are kept in
// sticky flags.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   en, tick              : tick acceptance gate and timestep pulse
//   clr_flags             : synchronous clear of sticky flags (set wins)
//   dp_start, dp_id       : datapath start pulse and neuron ID under update
//   dp_done, dp_spike     : datapath completion strobe and spike result
//   sweep_busy/sweep_done : sweep in progress / end-of-sweep pulse
//   ev_valid, ev_id,
//   ev_ready              : spike event stream (pop on valid & ready)
//   overrun, ev_drop,
//   timeout_err           : sticky error flags
// All outputs come from registers or decode of registered state.
// -----------------------------------------------------------------------------
module hh_update_scheduler
  import hh_sched_pkg::*;
#(
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int ID_W        = DEF_ID_W,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic            tick,
  input  logic            clr_flags,
  output logic            dp_start,
  output logic [ID_W-1:0] dp_id,
  input  logic            dp_done,
  input  logic            dp_spike,
  output logic            sweep_busy,
  output logic            sweep_done,
  output logic            ev_valid,
  output logic [ID_W-1:0] ev_id,
  input  logic            ev_ready,
  output logic            overrun,
  output logic            ev_drop,
  output logic            timeout_err
);

  localparam int              CNT_W   = wait_cnt_w(TIMEOUT);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_NEURONS - 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  state_e           state, state_nx;
  logic [ID_W-1:0]  id_q, id_nx;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nx, wait_inc;
  logic             ev_push;
  logic             timeout_hit;
  logic             fifo_empty;
  logic             fifo_full;
  logic             fifo_drop;

  // Saturating increment; the counter never needs to exceed TIMEOUT.
  assign wait_inc = (wait_cnt == TO_VAL) ? wait_cnt : wait_cnt + 1'b1;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nx    = state;
    id_nx       = id_q;
    wait_cnt_nx = wait_cnt;
    ev_push     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tick && en) begin
          state_nx = ST_ISSUE;
          id_nx    = '0;
        end
      end
      ST_ISSUE: begin
        wait_cnt_nx = '0;
        state_nx    = ST_WAIT;
      end
      ST_WAIT: begin
        wait_cnt_nx = wait_inc;
        if (dp_done) begin
          ev_push = dp_spike;
        end else if (wait_inc == TO_VAL) begin
          // Abandoned update: advance as if the neuron did not spike.
          timeout_hit = 1'b1;
        end
        if (dp_done || timeout_hit) begin
          if (id_q == LAST_ID) begin
            state_nx = ST_DONE;
          end else begin
            id_nx    = id_q + 1'b1;
            state_nx = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
        id_nx    = '0;
      end
      default: begin
        state_nx = ST_IDLE;
        id_nx    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      id_q     <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      id_q     <= id_nx;
      wait_cnt <= wait_cnt_nx;
    end
  end

  // Sticky flags: a set condition in the same cycle as clr_flags wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun     <= 1'b0;
      ev_drop     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      overrun     <= (tick && (state != ST_IDLE)) || (overrun && !clr_flags);
      ev_drop     <= fifo_drop   || (ev_drop && !clr_flags);
      timeout_err <= timeout_hit || (timeout_err && !clr_flags);
    end
  end

  spike_event_fifo #(
    .ID_W       (ID_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (ev_push),
    .push_id (id_q),
    .pop     (ev_ready),
    .head_id (ev_id),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .drop    (fifo_drop)
  );

  assign dp_start   = (state == ST_ISSUE);
  assign dp_id      = id_q;
  assign sweep_busy = (state != ST_IDLE);
  assign sweep_done = (state == ST_DONE);
  assign ev_valid   = ~fifo_empty;

endmodule

// File: tb/tb_hh_update_scheduler.sv
// -----------------------------------------------------------------------------
// tb_hh_update_scheduler
// Self-checking bench: a behavioural datapath answers every dp_start after
// rsp_k cycles (or never, for muted IDs); spiking IDs are queued in a
// scoreboard that follows the FIFO rules, and each popped event is compared
// against the scoreboard head. Directed sequences cover sweep timing,
// overflow, simultaneous push/pop, overrun, timeout and reset mid-sweep.
// -----------------------------------------------------------------------------
module tb_hh_update_scheduler;

  localparam int NUM_N = 4;
  localparam int IDW   = 2;
  localparam int DEPTH = 2;
  localparam int TO    = 15;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           en, tick, clr_flags;
  logic           dp_start;
  logic [IDW-1:0] dp_id;
  logic           dp_done, dp_spike;
  logic           sweep_busy, sweep_done;
  logic           ev_valid;
  logic [IDW-1:0] ev_id;
  logic           ev_ready;
  logic           overrun, ev_drop, timeout_err;

  hh_update_scheduler #(
    .NUM_NEURONS (NUM_N),
    .ID_W        (IDW),
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT     (TO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .tick        (tick),
    .clr_flags   (clr_flags),
    .dp_start    (dp_start),
    .dp_id       (dp_id),
    .dp_done     (dp_done),
    .dp_spike    (dp_spike),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done),
    .ev_valid    (ev_valid),
    .ev_id       (ev_id),
    .ev_ready    (ev_ready),
    .overrun     (overrun),
    .ev_drop     (ev_drop),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  wire [10:0] outs = {dp_start, dp_id, sweep_busy, sweep_done, ev_valid, ev_id,
                      overrun, ev_drop, timeout_err};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    while (!sweep_done && n < max_cyc) begin
      step();
      n++;
    end
    check("sweep_done_seen", sweep_done, 1);
  endtask

  // Behavioural datapath model
  logic [3:0] spike_mask, mute_mask;
  int         rsp_k;
  int         rsp_cnt  = 0;
  int         rsp_next = 0;
  int         rsp_id   = 0;
  bit         rsp_busy = 0;
  int         n_start  = 0;

  initial begin
    dp_done  = 1'b0;
    dp_spike = 1'b0;
    forever begin
      step();
      dp_done  = 1'b0;
      dp_spike = 1'b0;
      if (!reset_n) begin
        rsp_busy = 0;
        rsp_next = 0;
      end else if (dp_start) begin
        check("dp_id", dp_id, rsp_next);
        rsp_id   = rsp_next;
        rsp_next = (rsp_next + 1) % NUM_N;
        rsp_cnt  = rsp_k;
        rsp_busy = !mute_mask[rsp_id];
        n_start++;
      end else if (rsp_busy) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          dp_done  = 1'b1;
          dp_spike = spike_mask[rsp_id];
          rsp_busy = 0;
        end
      end
    end
  end

  // Scoreboard of expected events, updated on the same edges as the FIFO
  logic [IDW-1:0] sbq[$];
  bit             m_pop, m_push;
  int             n_popped = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sbq.delete();
    end else begin
      m_pop  = ev_ready && (sbq.size() > 0);
      m_push = dp_done && dp_spike;
      if (m_pop) void'(sbq.pop_front());
      if (m_push && sbq.size() < DEPTH) sbq.push_back(IDW'(rsp_id));
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("ev_valid", ev_valid, sbq.size() != 0);
      if (ev_valid && ev_ready && sbq.size() != 0) begin
        check("ev_id", ev_id, sbq[0]);
        n_popped++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  logic [31:0] v_start, v_done, v_busy, v_to;
  int          p0, s0;

  initial begin
    reset_n    = 1'b0;
    en         = 1'b1;
    tick       = 1'b0;
    clr_flags  = 1'b0;
    ev_ready   = 1'b0;
    rsp_k      = 2;
    spike_mask = 4'b0000;
    mute_mask  = 4'b0000;
    repeat (3) step();
    check("reset_outs", outs, 0);
    reset_n = 1'b1;
    step();
    check("idle_after_reset", outs, 0);

    // Basic sweep: k=2, only ID 2 spikes
    rsp_k = 2; spike_mask = 4'b0100; ev_ready = 1'b1;
    p0 = n_popped;
    v_start = '0; v_done = '0; v_busy = '0;
    tick = 1'b1;
    for (int c = 0; c < 16; c++) begin
      v_start[c] = dp_start;
      v_done[c]  = sweep_done;
      v_busy[c]  = sweep_busy;
      step();
      tick = 1'b0;
    end
    check("basic_start_cycles", v_start, 32'h0000_0492);
    check("basic_done_cycle",   v_done,  32'h0000_2000);
    check("basic_busy_cycles",  v_busy,  32'h0000_3FFE);
    repeat (3) step();
    check("basic_event_count", n_popped - p0, 1);

    // Overflow: all neurons spike, nothing popped
    rsp_k = 1; spike_mask = 4'b1111; ev_ready = 1'b0;
    p0 = n_popped;
    tick = 1'b1;
    step();
    tick = 1'b0;
    wait_done(50);
    step();
    check("ovf_drop", ev_drop, 1);
    check("ovf_valid", ev_valid, 1);
    ev_ready = 1'b1;
    repeat (3) step();
    ev_ready = 1'b0;
    check("ovf_popped", n_popped - p0, 2);
    check("ovf_empty", ev_valid, 0);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    check("ovf_drop_cleared", ev_drop, 0);

    // Simultaneous push and pop while full
    rsp_k = 2; spike_mask = 4'b0111; ev_ready = 1'b0;
    p0 = n_popped;
    tick = 1'b1;
    for (int c = 0; c < 16; c++) begin
      ev_ready = (c == 9);
      step();
      tick = 1'b0;
    end
    ev_ready = 1'b0;
    check("pp_no_drop", ev_drop, 0);
    check("pp_valid", ev_valid, 1);
    check("pp_popped_once", n_popped - p0, 1);
    ev_ready = 1'b1;
    repeat (3) step();
    check("pp_popped_total", n_popped - p0, 3);
    check("pp_drained", ev_valid, 0);

    // Overrun: second tick in WAIT, with clr_flags in the same cycle
    rsp_k = 2; spike_mask = 4'b0000; ev_ready = 1'b1;
    s0 = n_start;
    for (int c = 0; c < 20; c++) begin
      tick      = (c == 0) || (c == 5);
      clr_flags = (c == 5);
      step();
    end
    tick = 1'b0; clr_flags = 1'b0;
    check("ovr_updates", n_start - s0, 4);
    check("ovr_flag", overrun, 1);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    check("ovr_cleared", overrun, 0);

    // Tick with en=0 in IDLE: ignored, no flag
    en = 1'b0;
    s0 = n_start;
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("en0_busy", sweep_busy, 0);
    repeat (5) step();
    check("en0_updates", n_start - s0, 0);
    check("en0_overrun", overrun, 0);
    en = 1'b1;

    // Timeout: ID 1 never answers
    rsp_k = 2; mute_mask = 4'b0010; spike_mask = 4'b1000; ev_ready = 1'b1;
    v_start = '0; v_to = '0;
    tick = 1'b1;
    for (int c = 0; c < 22; c++) begin
      v_start[c] = dp_start;
      v_to[c]    = timeout_err;
      step();
      tick = 1'b0;
    end
    check("to_start_cycles", v_start, 32'h0010_0012);
    check("to_flag_cycles",  v_to,    32'h0030_0000);
    wait_done(50);
    step();
    mute_mask = 4'b0000;

    // Reset during WAIT for ID 1
    rsp_k = 3; spike_mask = 4'b0001; ev_ready = 1'b0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    repeat (5) step();
    check("mid_busy", sweep_busy, 1);
    check("mid_dp_id", dp_id, 1);
    check("mid_ev_valid", ev_valid, 1);
    check("mid_timeout_err", timeout_err, 1);
    #2 reset_n = 1'b0;
    #1 check("async_reset_outs", outs, 0);
    step();
    step();
    reset_n = 1'b1;
    v_done = '0;
    for (int c = 0; c < 4; c++) begin
      v_done[c] = sweep_done | sweep_busy;
      step();
    end
    check("post_reset_quiet", v_done, 0);
    rsp_k = 1; spike_mask = 4'b0000; ev_ready = 1'b1;
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("restart_dp_start", dp_start, 1);
    check("restart_dp_id", dp_id, 0);
    wait_done(50);
    repeat (3) step();
    check("sb_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
